// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run monitor: run-state encoding and counter defaults.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    RUN      = 3'd2,
    HALTED   = 3'd3,
    TIMEOUT  = 3'd4
  } run_state_t;

  localparam int unsigned CNT_WIDTH_DEF = 32;
  localparam logic [CNT_WIDTH_DEF-1:0] CNT_SAT = '1;

endpackage

// File: rtl/cpu_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter
  import cpu_run_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
  input  logic             CP,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for the multi-cycle CPU: sequences its reset, counts activity,
// and stops on a "b ." self-loop or a cycle budget with sticky status.
module cpu_run_monitor
  import cpu_run_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned HALT_REPEAT    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1500
) (
  input  logic                 CP,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 writePC,
  input  logic                 writeIR,
  input  logic                 writeReg,
  input  logic [PC_WIDTH-1:0]  PC,
  output logic                 cpu_reset,
  output logic                 running,
  output logic                 done,
  output logic                 timed_out,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] regw_count,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [PC_WIDTH-1:0]  last_pc
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_HALT  = REP_W'(HALT_REPEAT);

  run_state_t        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt, rep_nxt;
  logic [63:0]       cyc_next;
  logic              clr, in_run, halt_hit, timeout_hit;
  logic              cpu_reset_nxt, running_nxt, done_nxt, timed_out_nxt;

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    in_run    = (state == RUN);
    rep_nxt   = ((PC == last_pc) && (fetch_count != '0)) ? rep_cnt + REP_W'(1) : REP_W'(1);
    halt_hit  = in_run && writeIR && (rep_nxt == REP_HALT);
    // Timeout compares the post-increment (saturated) cycle count, so a budget
    // beyond the counter range can never fire.
    cyc_next  = (cycle_count == '1) ? 64'(cycle_count) : 64'(cycle_count) + 64'd1;
    timeout_hit = in_run && (cyc_next == 64'(TIMEOUT_CYCLES));

    case (state)
      IDLE, HALTED, TIMEOUT: begin
        if (start) begin
          state_nxt = RST_HOLD;
          clr       = 1'b1;
        end
      end
      RST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      RUN: begin
        if (halt_hit)         state_nxt = HALTED;
        else if (timeout_hit) state_nxt = TIMEOUT;
      end
      default: state_nxt = IDLE;
    endcase

    cpu_reset_nxt = (state_nxt == IDLE) || (state_nxt == RST_HOLD);
    running_nxt   = (state_nxt == RUN);
    done_nxt      = (state_nxt == HALTED) || (state_nxt == TIMEOUT);
    timed_out_nxt = (state_nxt == TIMEOUT);
  end

  always_ff @(posedge CP or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      last_pc   <= '0;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      cpu_reset <= cpu_reset_nxt;
      running   <= running_nxt;
      done      <= done_nxt;
      timed_out <= timed_out_nxt;
      if (clr) begin
        hold_cnt <= '0;
        rep_cnt  <= '0;
        last_pc  <= '0;
      end else begin
        if (state == RST_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
        if (in_run && writeIR) begin
          rep_cnt <= rep_nxt;
          last_pc <= PC;
        end
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .CP(CP), .reset(reset), .clr(clr), .inc(in_run), .q(cycle_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_fetch (
    .CP(CP), .reset(reset), .clr(clr), .inc(in_run && writeIR), .q(fetch_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_regw (
    .CP(CP), .reset(reset), .clr(clr), .inc(in_run && writeReg), .q(regw_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch (
    .CP(CP), .reset(reset), .clr(clr), .inc(in_run && writePC), .q(branch_count)
  );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench: three monitor configurations share one stimulus stream and
// are checked every cycle against a trace-replay model of the run rules.
module tb_cpu_run_monitor;

  localparam int unsigned RC = 2;
  localparam int unsigned HR = 3;
  localparam int unsigned NI = 3;

  typedef enum int {M_IDLE, M_HOLD, M_RUN, M_HALT, M_TO} mstate_t;
  typedef struct {
    mstate_t st;
    longint  cyc;
    longint  fet;
    longint  rgw;
    longint  brn;
    int      lpc;
  } exp_t;

  logic CP = 1'b0;
  always #5 CP = ~CP;

  logic       reset = 1'b1;
  logic       start, writePC, writeIR, writeReg;
  logic [7:0] PC;

  logic        o_cr   [NI];
  logic        o_run  [NI];
  logic        o_done [NI];
  logic        o_to   [NI];
  logic [31:0] o_cyc  [NI];
  logic [31:0] o_fet  [NI];
  logic [31:0] o_rgw  [NI];
  logic [31:0] o_brn  [NI];
  logic [7:0]  o_lpc  [NI];
  logic [3:0]  s_cyc, s_fet, s_rgw, s_brn;

  assign o_cyc[2] = {28'd0, s_cyc};
  assign o_fet[2] = {28'd0, s_fet};
  assign o_rgw[2] = {28'd0, s_rgw};
  assign o_brn[2] = {28'd0, s_brn};

  int to_lim [NI] = '{1500, 20, 1500};
  int cnt_w  [NI] = '{32, 32, 4};
  int start_e [NI];

  bit h_st[$], h_ir[$], h_rg[$], h_pw[$];
  int h_pc[$];

  int n_cmp = 0;
  int n_bad = 0;

  cpu_run_monitor u_main (
    .CP(CP), .reset(reset), .start(start), .writePC(writePC), .writeIR(writeIR),
    .writeReg(writeReg), .PC(PC), .cpu_reset(o_cr[0]), .running(o_run[0]),
    .done(o_done[0]), .timed_out(o_to[0]), .cycle_count(o_cyc[0]),
    .fetch_count(o_fet[0]), .regw_count(o_rgw[0]), .branch_count(o_brn[0]),
    .last_pc(o_lpc[0])
  );

  cpu_run_monitor #(.TIMEOUT_CYCLES(20)) u_to (
    .CP(CP), .reset(reset), .start(start), .writePC(writePC), .writeIR(writeIR),
    .writeReg(writeReg), .PC(PC), .cpu_reset(o_cr[1]), .running(o_run[1]),
    .done(o_done[1]), .timed_out(o_to[1]), .cycle_count(o_cyc[1]),
    .fetch_count(o_fet[1]), .regw_count(o_rgw[1]), .branch_count(o_brn[1]),
    .last_pc(o_lpc[1])
  );

  cpu_run_monitor #(.CNT_WIDTH(4)) u_sat (
    .CP(CP), .reset(reset), .start(start), .writePC(writePC), .writeIR(writeIR),
    .writeReg(writeReg), .PC(PC), .cpu_reset(o_cr[2]), .running(o_run[2]),
    .done(o_done[2]), .timed_out(o_to[2]), .cycle_count(s_cyc),
    .fetch_count(s_fet), .regw_count(s_rgw), .branch_count(s_brn),
    .last_pc(o_lpc[2])
  );

  function automatic longint sat_add(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v < mx) ? v + 1 : mx;
  endfunction

  // Replays the recorded input history from the accepted start edge up to edge e.
  function automatic exp_t eval(int i, int e);
    exp_t r;
    int   pcs[$];
    r.st = M_IDLE; r.cyc = 0; r.fet = 0; r.rgw = 0; r.brn = 0; r.lpc = 0;
    if (start_e[i] < 0) return r;
    if (e - start_e[i] < int'(RC)) begin
      r.st = M_HOLD;
      return r;
    end
    r.st = M_RUN;
    for (int j = start_e[i] + int'(RC) + 1; j <= e; j++) begin
      r.cyc = sat_add(r.cyc, cnt_w[i]);
      if (h_rg[j]) r.rgw = sat_add(r.rgw, cnt_w[i]);
      if (h_pw[j]) r.brn = sat_add(r.brn, cnt_w[i]);
      if (h_ir[j]) begin
        r.fet = sat_add(r.fet, cnt_w[i]);
        r.lpc = h_pc[j];
        pcs.push_back(h_pc[j]);
        if (pcs.size() >= int'(HR)) begin
          int same;
          same = 1;
          for (int q = 1; q < int'(HR); q++)
            if (pcs[pcs.size() - 1 - q] != h_pc[j]) same = 0;
          if (same == 1) begin
            r.st = M_HALT;
            return r;
          end
        end
      end
      if (r.cyc == longint'(to_lim[i])) begin
        r.st = M_TO;
        return r;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, expv);
    end
  endtask

  task automatic check_all();
    exp_t x;
    int   e;
    e = h_st.size() - 1;
    for (int i = 0; i < int'(NI); i++) begin
      x = eval(i, e);
      chk("cpu_reset",    i, 32'(o_cr[i]),   32'(x.st == M_IDLE || x.st == M_HOLD));
      chk("running",      i, 32'(o_run[i]),  32'(x.st == M_RUN));
      chk("done",         i, 32'(o_done[i]), 32'(x.st == M_HALT || x.st == M_TO));
      chk("timed_out",    i, 32'(o_to[i]),   32'(x.st == M_TO));
      chk("cycle_count",  i, o_cyc[i],       32'(x.cyc));
      chk("fetch_count",  i, o_fet[i],       32'(x.fet));
      chk("regw_count",   i, o_rgw[i],       32'(x.rgw));
      chk("branch_count", i, o_brn[i],       32'(x.brn));
      chk("last_pc",      i, 32'(o_lpc[i]),  32'(x.lpc));
    end
  endtask

  task automatic tick(input bit st, input bit ir, input int pc, input bit rg, input bit pw);
    exp_t pre;
    int   e;
    start = st; writeIR = ir; PC = 8'(pc); writeReg = rg; writePC = pw;
    @(posedge CP);
    h_st.push_back(st); h_ir.push_back(ir); h_rg.push_back(rg); h_pw.push_back(pw);
    h_pc.push_back(pc & 255);
    e = h_st.size() - 1;
    if (st) begin
      for (int i = 0; i < int'(NI); i++) begin
        pre = eval(i, e - 1);
        if (pre.st inside {M_IDLE, M_HALT, M_TO}) start_e[i] = e;
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0; writeIR = 1'b0; writePC = 1'b0; writeReg = 1'b0; PC = '0;
    h_st.delete(); h_ir.delete(); h_rg.delete(); h_pw.delete(); h_pc.delete();
    foreach (start_e[i]) start_e[i] = -1;
    #1;
    check_all();
    repeat (3) begin
      @(posedge CP);
      #1;
      check_all();
    end
    reset = 1'b1;
  endtask

  initial begin
    int halt_pcs [6] = '{0, 4, 8, 12, 12, 12};
    start = 1'b0; writeIR = 1'b0; writePC = 1'b0; writeReg = 1'b0; PC = '0;
    #2;

    // Power-up and idle
    do_reset();
    idle(5);

    // Normal halt on repeated PC
    tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("hold_a", 0, 32'(o_cr[0]), 32'd1);
    idle(1);
    chk("hold_b", 0, 32'(o_cr[0]), 32'd1);
    idle(1);
    chk("release", 0, 32'(o_cr[0]), 32'd0);
    foreach (halt_pcs[k]) begin
      tick(1'b0, 1'b1, halt_pcs[k], 1'b0, 1'b0);
      idle(3);
    end
    chk("halt_done", 0, 32'(o_done[0]), 32'd1);
    chk("halt_to",   0, 32'(o_to[0]),   32'd0);
    chk("halt_fet",  0, o_fet[0],       32'd6);
    chk("halt_lpc",  0, 32'(o_lpc[0]),  32'd12);
    idle(4);

    // Restart from HALTED, coincident strobes, then abort mid-run
    tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("restart_fet", 0, o_fet[0], 32'd0);
    chk("restart_cr",  0, 32'(o_cr[0]), 32'd1);
    idle(2);
    tick(1'b0, 1'b1, 16, 1'b1, 1'b1);
    chk("sim_fet", 0, o_fet[0], 32'd1);
    chk("sim_rgw", 0, o_rgw[0], 32'd1);
    chk("sim_brn", 0, o_brn[0], 32'd1);
    idle(2);
    do_reset();
    chk("abort_run", 0, 32'(o_run[0]), 32'd0);

    // Halt and timeout on the same cycle (TIMEOUT_CYCLES=20 instance)
    tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    idle(17);
    repeat (3) tick(1'b0, 1'b1, 32, 1'b0, 1'b0);
    chk("tie_done", 1, 32'(o_done[1]), 32'd1);
    chk("tie_to",   1, 32'(o_to[1]),   32'd0);
    chk("tie_cyc",  1, o_cyc[1],       32'd20);

    // Timeout with advancing PCs, then frozen counters
    do_reset();
    tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    for (int k = 0; k < 30; k++) tick(bit'(0), bit'(k % 2 == 0), k * 4, 1'b0, 1'b0);
    chk("to_flag", 1, 32'(o_to[1]), 32'd1);
    chk("to_cyc",  1, o_cyc[1],     32'd20);
    idle(10);
    chk("to_frozen", 1, o_cyc[1], 32'd20);

    // Saturation on the 4-bit instance
    do_reset();
    tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    repeat (20) tick(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(3);
    chk("sat_rgw",  2, o_rgw[2], 32'd15);
    chk("wide_rgw", 0, o_rgw[0], 32'd20);

    // Randomised runs with occasional restarts
    for (int r = 0; r < 10; r++) begin
      do_reset();
      tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
      repeat (100)
        tick(bit'($urandom_range(15) == 0), bit'($urandom_range(1)),
             int'($urandom_range(3)) * 4, bit'($urandom_range(1)), bit'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable, parametrised run controller and monitor for the multi-cycle CPU in simulation and FPGA bring-up.
- Sequences the CPU reset for a programmable number of cycles and counts cycles, fetches and register writes from the CPU strobes.
- Detects program completion ("b ." self-loop: same fetch PC repeated) or a timeout, then freezes and raises a sticky status.
- Replaces fixed-delay reset/finish scaffolding: the bench waits on done and reads the counters.

Parameters:
PC_WIDTH, 8, width of CPU PC bus
CNT_WIDTH, 32, width of all counters
RESET_CYCLES, 2, cycles cpu_reset is held high after start (>=1)
HALT_REPEAT, 3, consecutive fetches at identical PC that declare halt (>=2)
TIMEOUT_CYCLES, 1500, RUN cycles before timeout (>=1)

Ports:
CP  in  1  clock, rising edge
reset  in  1  asynchronous, active-low monitor reset
start  in  1  one-cycle pulse; begins a run from IDLE, HALTED or TIMEOUT
writePC  in  1  CPU PC-write strobe
writeIR  in  1  CPU IR-write (fetch) strobe
writeReg  in  1  CPU register-file write strobe
PC  in  PC_WIDTH  CPU PC, sampled when writeIR=1
cpu_reset  out  1  active-high reset driven to the CPU
running  out  1  high in RUN
done  out  1  sticky; high in HALTED or TIMEOUT
timed_out  out  1  sticky; high in TIMEOUT only
cycle_count  out  CNT_WIDTH  RUN cycles elapsed
fetch_count  out  CNT_WIDTH  writeIR pulses seen in RUN
regw_count  out  CNT_WIDTH  writeReg pulses seen in RUN
branch_count  out  CNT_WIDTH  writePC pulses seen in RUN
last_pc  out  PC_WIDTH  PC at most recent fetch

Behaviour:
- reset low (any time, async): state=IDLE; cpu_reset=1; running=done=timed_out=0; all counters, last_pc and repeat counter = 0.
- States: IDLE, RST_HOLD, RUN, HALTED, TIMEOUT. Encoding is in the package.
- IDLE: cpu_reset=1. On start -> RST_HOLD; clear counters, last_pc, repeat counter and hold counter.
- RST_HOLD: cpu_reset=1 for exactly RESET_CYCLES cycles (counted from the cycle after start). Then -> RUN; cpu_reset=0 from the first RUN cycle.
- RUN: running=1, cpu_reset=0.
  - cycle_count +1 every cycle.
  - fetch_count, regw_count and branch_count each +1 in any cycle where their strobe is high. Strobes are independent and may coincide.
  - On writeIR:
    - If PC==last_pc and fetch_count>0: repeat counter +1.
    - Otherwise: repeat counter = 1.
    - last_pc <= PC in both cases.
  - Halt fires when the repeat counter reaches HALT_REPEAT on a fetch; that fetch is counted. Next state is HALTED.
  - Timeout fires when cycle_count reaches TIMEOUT_CYCLES at the end of a cycle; next state is TIMEOUT.
  - If halt and timeout fire in the same cycle, HALTED wins.
- HALTED / TIMEOUT:
  - done=1; timed_out=1 only in TIMEOUT.
  - cpu_reset stays 0 so the CPU state remains inspectable.
  - Counters and last_pc frozen; CPU strobes ignored.
  - start -> RST_HOLD with counters cleared, as from IDLE.
- start in RST_HOLD or RUN is ignored.
- Counters saturate at all-ones and never wrap.
- Outputs are registered; status and counters are valid in the cycle after the triggering edge.
- reset asserted mid-run aborts immediately to IDLE and re-asserts cpu_reset asynchronously.

Decomposition:
- Package cpu_run_pkg holds:
  - state enum: IDLE=0, RST_HOLD=1, RUN=2, HALTED=3, TIMEOUT=4 (3-bit).
  - localparam for the saturation all-ones value derived from CNT_WIDTH.
- Sub-module sat_counter (parametrised width; ports: CP, reset, clr, inc, q): saturating counter with synchronous clear. Instantiated four times.
- The FSM and the repeat/hold counters stay in the top module.

Test Plan:
- Power-up: reset=0 for 3 cycles, then reset=1 with no start -> cpu_reset=1, done=0, all counters 0 indefinitely.
- Normal halt: start; drive fetches with PC=0,4,8,12,12,12 (one writeIR every 4 cycles) -> cpu_reset low exactly 2 cycles after start; HALTED after the third PC=12 fetch; fetch_count=6; last_pc=12; done=1; timed_out=0.
- Timeout: TIMEOUT_CYCLES=20; start; fetches at incrementing PCs -> TIMEOUT with cycle_count=20; timed_out=1; counters frozen for 10 further cycles.
- Simultaneous events: writePC, writeIR and writeReg high in the same cycle -> each counter +1. Arrange halt and timeout on the same cycle -> HALTED, timed_out=0.
- Restart and abort:
  - start from HALTED -> counters zeroed; cpu_reset=1 for 2 cycles.
  - reset pulled low mid-RUN -> same-cycle cpu_reset=1, state IDLE.
- Saturation: CNT_WIDTH=4; 20 writeReg pulses in RUN -> regw_count=15 and held.
